// File: rtl/decode_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_control_pipe
// Description : Pipelined decode-stage control unit with ID/EX register,
//               load-use bubble insertion and two-word immediate sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_control_pipe #(
    parameter int INSTR_W    = 16,
    parameter int OPCODE_W   = 6,
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 4,
    localparam int SHAMT_W   = INSTR_W - OPCODE_W - 2 * REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  flush,
    output logic                  stall,
    output logic                  illegal,
    output logic                  ex_valid,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  ex_alu_en,
    output logic                  ex_shamt_sel,
    output logic                  ex_imm_sel,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_addr_sel,
    output logic                  ex_mem_data_sel,
    output logic [2:0]            ex_wb,
    output logic [REG_ADDR_W-1:0] ex_rdst,
    output logic [REG_ADDR_W-1:0] ex_rsrc,
    output logic [SHAMT_W-1:0]    ex_shamt,
    output logic [INSTR_W-1:0]    ex_imm
);

    localparam int SUB_W = OPCODE_W - 2;

    localparam logic [0:0] c_DECODE = 1'b0;
    localparam logic [0:0] c_IMM    = 1'b1;

    localparam logic [2:0] c_WB_NONE = 3'b000;
    localparam logic [2:0] c_WB_MEM  = 3'b100;
    localparam logic [2:0] c_WB_ALU  = 3'b101;
    localparam logic [2:0] c_WB_IMM  = 3'b110;

    // Instruction fields
    logic [OPCODE_W-1:0]   w_opcode;
    logic [1:0]            w_class;
    logic [SUB_W-1:0]      w_sub;
    logic [REG_ADDR_W-1:0] w_rdst;
    logic [REG_ADDR_W-1:0] w_rsrc;
    logic [SHAMT_W-1:0]    w_shamt;

    assign w_opcode = instr[INSTR_W-1 -: OPCODE_W];
    assign w_class  = w_opcode[OPCODE_W-1 -: 2];
    assign w_sub    = w_opcode[SUB_W-1:0];
    assign w_rdst   = instr[INSTR_W-OPCODE_W-1 -: REG_ADDR_W];
    assign w_rsrc   = instr[INSTR_W-OPCODE_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_shamt  = instr[SHAMT_W-1:0];

    // Decoded controls for the word currently on instr
    logic               w_legal;
    logic               w_nop;
    logic               w_twoWord;
    logic               w_readsRdst;
    logic               w_readsRsrc;
    logic [ALUOP_W-1:0] w_aluOp;
    logic               w_aluEn;
    logic               w_shamtSel;
    logic               w_immSel;
    logic               w_memRead;
    logic               w_memWrite;
    logic               w_addrSel;
    logic [2:0]         w_wb;

    always_comb begin
        w_legal     = 1'b0;
        w_nop       = 1'b0;
        w_twoWord   = 1'b0;
        w_readsRdst = 1'b0;
        w_readsRsrc = 1'b0;
        w_aluOp     = '0;
        w_aluEn     = 1'b0;
        w_shamtSel  = 1'b0;
        w_immSel    = 1'b0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_addrSel   = 1'b0;
        w_wb        = c_WB_NONE;
        case (w_class)
            2'b00: begin
                if (w_sub == SUB_W'(0)) begin
                    w_legal = 1'b1;
                    w_nop   = 1'b1;
                end else if (w_sub <= SUB_W'(7)) begin
                    w_legal     = 1'b1;
                    w_aluOp     = w_opcode[ALUOP_W-1:0];
                    w_aluEn     = 1'b1;
                    w_wb        = c_WB_ALU;
                    w_readsRdst = 1'b1;
                    // NOT and the shifts are single-operand on Rdst
                    w_readsRsrc = (w_sub >= SUB_W'(2)) && (w_sub <= SUB_W'(5));
                    w_shamtSel  = (w_sub >= SUB_W'(6));
                end
            end
            2'b01: begin
                if (w_sub == SUB_W'(0)) begin
                    w_legal     = 1'b1;
                    w_memRead   = 1'b1;
                    w_wb        = c_WB_MEM;
                    w_readsRsrc = 1'b1;
                end else if (w_sub == SUB_W'(1)) begin
                    w_legal     = 1'b1;
                    w_memWrite  = 1'b1;
                    w_addrSel   = 1'b1;
                    w_readsRsrc = 1'b1;
                    w_readsRdst = 1'b1;
                end
            end
            2'b10: begin
                if (w_sub == SUB_W'(0)) begin
                    w_legal   = 1'b1;
                    w_twoWord = 1'b1;
                    w_wb      = c_WB_IMM;
                end else if (w_sub == SUB_W'(1)) begin
                    w_legal     = 1'b1;
                    w_twoWord   = 1'b1;
                    w_aluOp     = ALUOP_W'(2);
                    w_aluEn     = 1'b1;
                    w_immSel    = 1'b1;
                    w_wb        = c_WB_ALU;
                    w_readsRdst = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [0:0]            r_state;
    logic                  r_exValid;
    logic [ALUOP_W-1:0]    r_exAluOp;
    logic                  r_exAluEn;
    logic                  r_exShamtSel;
    logic                  r_exImmSel;
    logic                  r_exMemRead;
    logic                  r_exMemWrite;
    logic                  r_exAddrSel;
    logic                  r_exDataSel;
    logic [2:0]            r_exWb;
    logic [REG_ADDR_W-1:0] r_exRdst;
    logic [REG_ADDR_W-1:0] r_exRsrc;
    logic [SHAMT_W-1:0]    r_exShamt;
    logic [INSTR_W-1:0]    r_exImm;

    // First word of a two-word instruction, held until its immediate arrives
    logic [ALUOP_W-1:0]    r_heldAluOp;
    logic                  r_heldAluEn;
    logic                  r_heldImmSel;
    logic [2:0]            r_heldWb;
    logic [REG_ADDR_W-1:0] r_heldRdst;
    logic [REG_ADDR_W-1:0] r_heldRsrc;
    logic [SHAMT_W-1:0]    r_heldShamt;

    logic w_inDecode;
    logic w_hazard;
    logic w_consume;

    assign w_inDecode = (r_state == c_DECODE);
    assign w_hazard   = w_inDecode && in_valid && r_exValid && r_exMemRead &&
                        ((w_readsRdst && (w_rdst == r_exRdst)) ||
                         (w_readsRsrc && (w_rsrc == r_exRdst)));
    assign stall      = !rst && !flush && w_hazard;
    assign illegal    = !rst && !flush && w_inDecode && in_valid && !w_legal;
    assign w_consume  = w_inDecode && in_valid && !w_hazard && w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_DECODE;
            r_heldAluOp  <= '0;
            r_heldAluEn  <= 1'b0;
            r_heldImmSel <= 1'b0;
            r_heldWb     <= c_WB_NONE;
            r_heldRdst   <= '0;
            r_heldRsrc   <= '0;
            r_heldShamt  <= '0;
        end else if (flush) begin
            r_state <= c_DECODE;
        end else if (w_inDecode) begin
            if (w_consume && w_twoWord) begin
                r_state      <= c_IMM;
                r_heldAluOp  <= w_aluOp;
                r_heldAluEn  <= w_aluEn;
                r_heldImmSel <= w_immSel;
                r_heldWb     <= w_wb;
                r_heldRdst   <= w_rdst;
                r_heldRsrc   <= w_rsrc;
                r_heldShamt  <= w_shamt;
            end
        end else if (in_valid) begin
            r_state <= c_DECODE;
        end
    end

    // ID/EX register: bubble unless an instruction issues this cycle
    always_ff @(posedge clk) begin
        r_exValid    <= 1'b0;
        r_exAluOp    <= '0;
        r_exAluEn    <= 1'b0;
        r_exShamtSel <= 1'b0;
        r_exImmSel   <= 1'b0;
        r_exMemRead  <= 1'b0;
        r_exMemWrite <= 1'b0;
        r_exAddrSel  <= 1'b0;
        r_exDataSel  <= 1'b0;
        r_exWb       <= c_WB_NONE;
        r_exRdst     <= '0;
        r_exRsrc     <= '0;
        r_exShamt    <= '0;
        r_exImm      <= '0;
        if (!rst && !flush) begin
            if (w_consume && !w_twoWord) begin
                r_exValid <= 1'b1;
                if (!w_nop) begin
                    r_exAluOp    <= w_aluOp;
                    r_exAluEn    <= w_aluEn;
                    r_exShamtSel <= w_shamtSel;
                    r_exMemRead  <= w_memRead;
                    r_exMemWrite <= w_memWrite;
                    r_exAddrSel  <= w_addrSel;
                    r_exWb       <= w_wb;
                    r_exRdst     <= w_rdst;
                    r_exRsrc     <= w_rsrc;
                    r_exShamt    <= w_shamt;
                end
            end else if (!w_inDecode && in_valid) begin
                r_exValid  <= 1'b1;
                r_exAluOp  <= r_heldAluOp;
                r_exAluEn  <= r_heldAluEn;
                r_exImmSel <= r_heldImmSel;
                r_exWb     <= r_heldWb;
                r_exRdst   <= r_heldRdst;
                r_exRsrc   <= r_heldRsrc;
                r_exShamt  <= r_heldShamt;
                r_exImm    <= instr;
            end
        end
    end

    assign ex_valid        = r_exValid;
    assign ex_alu_op       = r_exAluOp;
    assign ex_alu_en       = r_exAluEn;
    assign ex_shamt_sel    = r_exShamtSel;
    assign ex_imm_sel      = r_exImmSel;
    assign ex_mem_read     = r_exMemRead;
    assign ex_mem_write    = r_exMemWrite;
    assign ex_mem_addr_sel = r_exAddrSel;
    assign ex_mem_data_sel = r_exDataSel;
    assign ex_wb           = r_exWb;
    assign ex_rdst         = r_exRdst;
    assign ex_rsrc         = r_exRsrc;
    assign ex_shamt        = r_exShamt;
    assign ex_imm          = r_exImm;

endmodule
`default_nettype wire

// File: doc/decode_control_pipe.md
Name: decode_control_pipe

Overview:
Parametrised, pipelined successor of the decode-stage control unit. It decodes a full instruction word into control signals and registers them into the ID/EX boundary. It detects load-use hazards and inserts bubbles, sequences two-word immediate instructions with a small FSM, and handles flush and illegal opcodes. It sits between the IF/ID register and the execute stage.

Parameters:
INSTR_W, 16, instruction word width; also the immediate width
OPCODE_W, 6, opcode field width; opcode = instr[INSTR_W-1 -: OPCODE_W]
REG_ADDR_W, 3, register address width; rdst follows opcode, rsrc follows rdst, shamt = the remaining low bits (SHAMT_W = INSTR_W-OPCODE_W-2*REG_ADDR_W)
ALUOP_W, 4, ALU operation width; equals the low ALUOP_W bits of the opcode

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instr holds a valid word from IF/ID
instr  in  INSTR_W  instruction or immediate word
flush  in  1  kill the in-flight decode (branch/redirect)
stall  out  1  word not consumed this cycle; IF/ID and PC hold
illegal  out  1  one-cycle pulse: undefined opcode dropped
ex_valid  out  1  ID/EX holds a real instruction
ex_alu_op  out  ALUOP_W  ALU operation
ex_alu_en  out  1  ALU enable
ex_shamt_sel  out  1  0 Rdst, 1 shamt
ex_imm_sel  out  1  operand B is ex_imm
ex_mem_read  out  1  memory read
ex_mem_write  out  1  memory write
ex_mem_addr_sel  out  1  0 Rsrc, 1 Rdst
ex_mem_data_sel  out  1  0 Rsrc, 1 Rdst
ex_wb  out  3  {reg_write, wb_sel}: MEM 100, ALU 101, IMM 110, none 000
ex_rdst  out  REG_ADDR_W  destination register
ex_rsrc  out  REG_ADDR_W  source register
ex_shamt  out  SHAMT_W  shift amount
ex_imm  out  INSTR_W  immediate

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset: every ex_* output = 0, state = DECODE, stall = 0, illegal = 0. No X/Z values are ever driven; unused fields are 0.
- Bubble: ex_valid = 0 and all ex_* controls = 0 (ex_wb = 000).
- Opcode classes use opcode[5:4] (shown for default widths):
  - 00 R-type, ex_alu_op = opcode[3:0]:
    - 0000 NOP: bubble with ex_valid = 1, ex_wb = 000.
    - 0001 NOT, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR: alu_en = 1, wb = 101.
    - 0110 SHL, 0111 SHR: add shamt_sel = 1.
    - 1000..1111: illegal.
  - 01 memory:
    - 0000 LDD: mem_read = 1, addr_sel = 0, wb = 100.
    - 0001 STD: mem_write = 1, addr_sel = 1, data_sel = 0, wb = 000.
    - Others: illegal.
  - 10 two-word:
    - 0000 LDM: wb = 110.
    - 0001 IADD: alu_op = 0010, alu_en = 1, imm_sel = 1, wb = 101.
    - Others: illegal.
  - 11: illegal.
- Latency: a single-word instruction consumed at edge N appears on ex_* after edge N.
- Registers read per instruction:
  - NOT, SHL, SHR, IADD read Rdst.
  - ADD, SUB, AND, OR read Rsrc and Rdst.
  - LDD reads Rsrc.
  - STD reads Rsrc and Rdst.
  - NOP, LDM read nothing.
- Load-use hazard, combinational in DECODE:
  - Condition: in_valid & ex_valid & ex_mem_read, and the decoded instruction reads ex_rdst.
  - Effect: stall = 1 and a bubble is loaded into ex_*; the word is not consumed.
  - The next cycle re-decodes the same word with no hazard, so each load-use stalls exactly 1 cycle.
- FSM states DECODE and IMM:
  - DECODE, two-word opcode consumed (no hazard): latch its decoded controls and fields internally, load a bubble into ex_*, go to IMM.
  - IMM with in_valid: consume the word as ex_imm, issue the held instruction (ex_valid = 1), return to DECODE. No hazard check is made on the immediate word.
  - IMM without in_valid: hold state, ex_* = bubble.
  - stall is never asserted in IMM.
- Illegal opcode: word consumed, bubble issued, illegal = 1 for one cycle, state unchanged (DECODE).
- in_valid = 0 in DECODE: bubble issued, stall = 0.
- Priority: rst > flush > hazard stall > normal decode.
  - flush: bubble into ex_*, state = DECODE, any held two-word instruction dropped; stall = 0 and illegal = 0 that cycle.
  - flush and a hazard in the same cycle: flush wins, stall = 0.
- Reset mid two-word sequence: returns to DECODE; the held instruction is discarded.

Test Plan:
- rst = 1 for 2 cycles while driving ADD -> all ex_* = 0, stall = 0; ADD(r1,r2) consumed after release -> ex_valid = 1, ex_alu_op = 0010, ex_wb = 101, ex_rdst = 1, ex_rsrc = 2 one edge later.
- LDD r3,[r1] then ADD r3,r4 back-to-back -> stall = 1 for exactly 1 cycle, one bubble, then ADD issues with ex_rdst = 3.
- LDM r5 with immediate word 0xBEEF, in_valid low for 2 cycles between the two words -> bubbles meanwhile, then ex_wb = 110, ex_rdst = 5, ex_imm = 0xBEEF, ex_valid = 1.
- IADD first word consumed, flush asserted in IMM, next word 0x0003 -> treated as an opcode in DECODE, no IADD issued.
- Opcode 6'b110000 -> illegal pulses 1 cycle, ex_valid = 0; following NOT r2 -> ex_alu_op = 0001, ex_wb = 101.
- LDD r2 then STD (Rsrc = 2) with flush in the stall cycle -> stall = 0, bubble, state DECODE.
